// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
//   Memory-backed APB completer. It accepts the setup/access handshake from an
//   APB master and serves a byte-strobed store of DEPTH words. Every transfer
//   waits a fixed number of wait states before the response. An address that
//   is below BASE_ADDR, past the last word, or not word aligned is "bad".
//   Writes to a bad address never change the store, and reads from one
//   return 0.
//
//   Optional feature (macro APB_SLAVE_SLVERR_EN):
//     defined   -> slverr reports bad addresses in the response cycle
//     undefined -> slverr is tied 0; bad accesses still complete normally
//
// Ports
//   clk     in   clock, rising edge
//   rst     in   synchronous reset, active-high (also clears the store)
//   sel     in   slave select
//   enable  in   access phase indicator
//   write   in   1 = write, 0 = read
//   strobe  in   byte-lane write enables
//   addr    in   byte address
//   wdata   in   write data
//   ready   out  transfer complete, high for exactly one cycle (registered)
//   rdata   out  read data, valid while ready=1 (registered)
//   slverr  out  error response, valid while ready=1 (registered)
// -----------------------------------------------------------------------------
module apb_slave_mem #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH       = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sel,
  input  logic                    enable,
  input  logic                    write,
  input  logic [DATA_WIDTH/8-1:0] strobe,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    slverr
);

  localparam int unsigned           STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned           IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_W    = ADDR_WIDTH'(DEPTH);
  localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    write_q, write_d;
  logic [STRB_WIDTH-1:0]   strobe_q, strobe_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    bad_q, bad_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  // Address decode of the live bus; only meaningful in the setup cycle.
  logic [ADDR_WIDTH-1:0]   word_off;
  logic [IDX_W-1:0]        idx;
  logic                    bad;

  assign word_off = (addr - BASE_ADDR) >> 2;
  assign idx      = word_off[IDX_W-1:0];
  assign bad      = (addr < BASE_ADDR) || (word_off >= DEPTH_W) || (addr[1:0] != 2'b00);

  // With zero wait states the response is loaded at the setup edge itself,
  // before the transfer has been latched, so take the live decode in IDLE.
  logic                    rd_write, rd_bad;
  logic [IDX_W-1:0]        rd_idx;

  assign rd_write = (state_q == S_IDLE) ? write : write_q;
  assign rd_bad   = (state_q == S_IDLE) ? bad   : bad_q;
  assign rd_idx   = (state_q == S_IDLE) ? idx   : idx_q;

  // Store update happens on the edge that closes the response cycle, and only
  // if the master is still presenting the access there.
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_wword;

  assign mem_we = (state_q == S_RESP) && sel && enable && write_q && !bad_q;

  always_comb begin
    mem_wword = mem_q[idx_q];
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (strobe_q[b]) mem_wword[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end

  logic load_resp;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    strobe_d  = strobe_q;
    wdata_d   = wdata_q;
    idx_d     = idx_q;
    bad_d     = bad_q;
    load_resp = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel && !enable) begin
          write_d  = write;
          strobe_d = strobe;
          wdata_d  = wdata;
          idx_d    = idx;
          bad_d    = bad;
          if (WAIT_CYCLES == 0) begin
            state_d   = S_RESP;
            load_resp = 1'b1;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!sel) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d   = S_RESP;
          load_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = load_resp;
    rdata_d = (load_resp && !rd_write && !rd_bad) ? mem_q[rd_idx] : '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      write_q  <= 1'b0;
      strobe_q <= '0;
      wdata_q  <= '0;
      idx_q    <= '0;
      bad_q    <= 1'b0;
      // NOTE: the store itself is cleared by reset, which rules out mapping it
      // onto a RAM macro; it is built from flops on purpose.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      write_q  <= write_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
      idx_q    <= idx_d;
      bad_q    <= bad_d;
      if (mem_we) mem_q[idx_q] <= mem_wword;
    end
  end

  assign ready = ready_q;
  assign rdata = rdata_q;

`ifdef APB_SLAVE_SLVERR_EN
  logic slverr_q, slverr_d;

  assign slverr_d = load_resp && rd_bad;

  always_ff @(posedge clk) begin
    if (rst) slverr_q <= 1'b0;
    else     slverr_q <= slverr_d;
  end

  assign slverr = slverr_q;
`else
  assign slverr = 1'b0;
`endif

  // Master-side protocol checks.
  a_stable_access: assert property (@(posedge clk) disable iff (rst)
    (sel && enable && state_q != S_IDLE) |-> ($stable(addr) && $stable(write) && $stable(wdata)));

  a_enable_needs_sel: assert property (@(posedge clk) disable iff (rst)
    enable |-> sel);

endmodule

// File: tb/tb_apb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_mem
//   Drives two apb_slave_mem instances (no wait states and three wait states)
//   on separate buses. Expected read data, error flags and latencies come from
//   a word-array model of the store built from the address/strobe rules.
// -----------------------------------------------------------------------------
module tb_apb_slave_mem;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0;
`ifdef APB_SLAVE_SLVERR_EN
  localparam bit SLV_EN = 1'b1;
`else
  localparam bit SLV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel, enable, write, ready, slverr;
  logic [3:0]  strobe [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [31:0] rdata  [2];

  always #5 clk = ~clk;

  apb_slave_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .sel(sel[0]), .enable(enable[0]), .write(write[0]),
    .strobe(strobe[0]), .addr(addr[0]), .wdata(wdata[0]),
    .ready(ready[0]), .rdata(rdata[0]), .slverr(slverr[0])
  );

  apb_slave_mem #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .sel(sel[1]), .enable(enable[1]), .write(write[1]),
    .strobe(strobe[1]), .addr(addr[1]), .wdata(wdata[1]),
    .ready(ready[1]), .rdata(rdata[1]), .slverr(slverr[1])
  );

  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  logic [31:0] model [2][DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit addr_bad(input logic [31:0] a);
    return (a < BASE) || (((a - BASE) >> 2) >= DEPTH) || (a[1:0] != 2'b00);
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) model[d][i] = '0;
  endtask

  // One complete APB transfer on bus d, started mid-cycle.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] st,
                      output logic [31:0] rd);
    int          waits;
    bit          got, bad;
    logic [31:0] exp_rd;
    logic        err;
    bad    = addr_bad(a);
    exp_rd = '0;
    if (!wr && !bad) exp_rd = model[d][widx(a)];
    sel[d] = 1'b1; enable[d] = 1'b0; write[d] = wr;
    addr[d] = a; wdata[d] = wd; strobe[d] = st;
    @(posedge clk); #1;
    enable[d] = 1'b1;
    waits = 0; got = 1'b0; rd = '0; err = 1'b0;
    while (!got && waits < 40) begin
      @(negedge clk);
      if (ready[d] === 1'b1) begin
        got = 1'b1; rd = rdata[d]; err = slverr[d];
      end else begin
        waits++;
      end
    end
    check($sformatf("latency d%0d a=%h", d, a), 64'(waits), 64'(wait_of(d)));
    check($sformatf("rdata d%0d a=%h wr=%0d", d, a, wr), 64'(rd), 64'(exp_rd));
    check($sformatf("slverr d%0d a=%h", d, a), 64'(err), 64'(SLV_EN && bad));
    @(posedge clk); #1;
    sel[d] = 1'b0; enable[d] = 1'b0;
    if (wr && !bad)
      for (int b = 0; b < 4; b++)
        if (st[b]) model[d][widx(a)][8*b +: 8] = wd[8*b +: 8];
    @(negedge clk);
    check($sformatf("post_resp d%0d", d), 64'({ready[d], slverr[d], rdata[d]}), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a, wd;
    int          hits;
    bit          wr;
    int          d;

    rst = 1'b1; sel = '0; enable = '0; write = '0;
    for (int i = 0; i < 2; i++) begin
      strobe[i] = '0; addr[i] = '0; wdata[i] = '0;
    end
    clear_model();

    // Reset held for two cycles, then both endpoints must sit idle.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset d0", 64'({ready[0], slverr[0], rdata[0]}), 64'(0));
    check("reset d1", 64'({ready[1], slverr[1], rdata[1]}), 64'(0));

    xfer(0, 1'b0, 32'h0, '0, '0, rd);

    // Write then read back with no wait states.
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
    xfer(0, 1'b0, 32'h10, '0, '0, rd);
    check("wr_rd 0x10", 64'(rd), 64'(32'hDEADBEEF));

    // Partial strobe merges lanes 0 and 2 only.
    xfer(0, 1'b1, 32'h8, 32'h11223344, 4'hF, rd);
    xfer(0, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, rd);
    xfer(0, 1'b0, 32'h8, '0, '0, rd);
    check("partial strobe", 64'(rd), 64'(32'h11BB33DD));

    // A write with no strobes leaves the word alone.
    xfer(0, 1'b1, 32'h10, 32'h0, 4'h0, rd);
    xfer(0, 1'b0, 32'h10, '0, '0, rd);
    check("zero strobe", 64'(rd), 64'(32'hDEADBEEF));

    // Three wait states.
    xfer(1, 1'b0, 32'h4, '0, '0, rd);
    xfer(1, 1'b1, 32'h4, 32'h5A5AA5A5, 4'hF, rd);
    xfer(1, 1'b0, 32'h4, '0, '0, rd);

    // Error path: out-of-range word aliases onto word 0 if truncated.
    xfer(0, 1'b1, 32'h0, 32'h01020304, 4'hF, rd);
    xfer(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, rd);
    xfer(0, 1'b0, 32'h100, '0, '0, rd);
    xfer(0, 1'b0, 32'h0, '0, '0, rd);
    check("bad write no alias", 64'(rd), 64'(32'h01020304));
    xfer(0, 1'b1, 32'h6, 32'hFFFFFFFF, 4'hF, rd);
    xfer(0, 1'b0, 32'h6, '0, '0, rd);
    xfer(0, 1'b1, 32'hFC, 32'h600DCAFE, 4'hF, rd);
    xfer(0, 1'b0, 32'hFC, '0, '0, rd);
    xfer(1, 1'b0, 32'h100, '0, '0, rd);

    // Access phase with no preceding setup is ignored.
    sel[0] = 1'b1; enable[0] = 1'b1; write[0] = 1'b0; addr[0] = 32'h10;
    hits = 0;
    repeat (3) begin
      @(negedge clk);
      if (ready[0] !== 1'b0) hits++;
    end
    check("no setup ignored", 64'(hits), 64'(0));
    sel[0] = 1'b0; enable[0] = 1'b0;

    // Abort in the second wait cycle of a write.
    xfer(1, 1'b1, 32'h20, 32'h0BADF00D, 4'hF, rd);
    sel[1] = 1'b1; enable[1] = 1'b0; write[1] = 1'b1;
    addr[1] = 32'h20; wdata[1] = 32'hFFFFFFFF; strobe[1] = 4'hF;
    @(posedge clk); #1 enable[1] = 1'b1;
    @(posedge clk); #1 sel[1] = 1'b0; enable[1] = 1'b0;
    hits = 0;
    repeat (6) begin
      @(negedge clk);
      if (ready[1] !== 1'b0) hits++;
    end
    check("abort no ready", 64'(hits), 64'(0));
    xfer(1, 1'b0, 32'h20, '0, '0, rd);
    check("abort word kept", 64'(rd), 64'(32'h0BADF00D));

    // Randomised traffic on both buses, biased towards a few words.
    for (int n = 0; n < 60; n++) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      case ($urandom_range(0, 7))
        0:       a = 32'h100 + ($urandom_range(0, 15) << 2);
        1:       a = ($urandom_range(0, 15) << 2) | $urandom_range(1, 3);
        default: a = $urandom_range(0, 15) << 2;
      endcase
      xfer(d, wr, a, wd, 4'($urandom_range(0, 15)), rd);
    end

    // Reset arriving while a write waits; the bus keeps sel/enable high.
    xfer(0, 1'b1, 32'h10, 32'h12345678, 4'hF, rd);
    xfer(1, 1'b1, 32'h4, 32'hCAFEF00D, 4'hF, rd);
    sel[1] = 1'b1; enable[1] = 1'b0; write[1] = 1'b1;
    addr[1] = 32'h4; wdata[1] = 32'h87654321; strobe[1] = 4'hF;
    @(posedge clk); #1 enable[1] = 1'b1; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    clear_model();
    @(negedge clk);
    check("reset in wait", 64'({ready[1], slverr[1], rdata[1]}), 64'(0));
    hits = 0;
    repeat (2) begin
      @(negedge clk);
      if (ready[1] !== 1'b0) hits++;
    end
    check("idle after reset", 64'(hits), 64'(0));
    sel[1] = 1'b0; enable[1] = 1'b0;
    xfer(0, 1'b0, 32'h10, '0, '0, rd);
    check("mem cleared d0", 64'(rd), 64'(0));
    xfer(1, 1'b0, 32'h4, '0, '0, rd);
    check("mem cleared d1", 64'(rd), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
